// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
// Module      : term_pkg
// Description : Shared definitions for the character row write controller:
//               geometry defaults, command encodings and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package term_pkg;

    // Row geometry defaults
    localparam int          TERM_DEPTH = 40;
    localparam int          TERM_WIDTH = 6;
    localparam logic [5:0]  TERM_BLANK = 6'h20;

    // Cursor / phase width (columns 0..63 addressable)
    localparam int          COL_W      = 6;

    // wr_cmd encodings
    typedef enum logic [1:0] {
        CMD_CHAR  = 2'b00,
        CMD_CR    = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_RSVD  = 2'b11
    } wr_cmd_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_COL   = 2'd1,
        ST_CLEAR_WAIT = 2'd2,
        ST_CLEARING   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/char_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : char_write_ctrl_if
// Description : Command handshake, shift-memory drive and cursor status bundle
//               of the character row write controller.
//               master : command source / memory observer
//               slave  : the controller
//               Signals: wr_valid, wr_cmd, wr_data -> slave;
//                        wr_ready, busy, mem_rc, mem_in, cursor_col,
//                        cursor_hit, line_wrap -> master.
// Revision    : 1.0 - initial release
// ============================================================================
interface char_write_ctrl_if
    import term_pkg::*;
#(
    parameter int WIDTH = TERM_WIDTH
);
    logic              wr_valid;
    logic [1:0]        wr_cmd;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_ready;
    logic              mem_rc;
    logic [WIDTH-1:0]  mem_in;
    logic [COL_W-1:0]  cursor_col;
    logic              cursor_hit;
    logic              line_wrap;
    logic              busy;

    modport master (
        output wr_valid, wr_cmd, wr_data,
        input  wr_ready, mem_rc, mem_in, cursor_col, cursor_hit, line_wrap, busy
    );

    modport slave (
        input  wr_valid, wr_cmd, wr_data,
        output wr_ready, mem_rc, mem_in, cursor_col, cursor_hit, line_wrap, busy
    );
endinterface
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Free-running modulo-MODULUS counter, +1 per clock.
//               clk   : clock
//               rst_n : synchronous active-low reset (count -> 0)
//               count : current value 0..MODULUS-1
//               wrap  : high while count == MODULUS-1 (next edge wraps to 0)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int MODULUS = 40,
    parameter int W       = 6
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    output logic [W-1:0]      count,
    output logic              wrap
);
    localparam logic [W-1:0] c_last = W'(MODULUS - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = (count_q == c_last) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = (count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/char_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : char_write_ctrl
// Description : Write controller for a recirculating character row shift
//               memory. The memory shifts every clock; a phase counter tracks
//               which column sits at the memory head. Commands write one
//               character at the cursor, return the cursor, or blank the row.
//               clk   : clock
//               rst_n : synchronous active-low reset
//               bus   : char_write_ctrl_if.slave (command handshake, memory
//                       drive mem_rc/mem_in, cursor status)
// Revision    : 1.0 - initial release
// ============================================================================
module char_write_ctrl
    import term_pkg::*;
#(
    parameter int               DEPTH = TERM_DEPTH,
    parameter int               WIDTH = TERM_WIDTH,
    parameter logic [WIDTH-1:0] BLANK = WIDTH'(TERM_BLANK)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    char_write_ctrl_if.slave bus
);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(DEPTH - 1);

    logic [COL_W-1:0] w_phase;
    logic             w_phase_last;

    state_e           state_q,  state_d;
    logic [COL_W-1:0] cursor_q, cursor_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             wrap_q,   wrap_d;

    logic             w_mem_rc;
    logic [WIDTH-1:0] w_mem_in;

    mod_counter #(
        .MODULUS (DEPTH),
        .W       (COL_W)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .count (w_phase),
        .wrap  (w_phase_last)
    );

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        data_d   = data_q;
        wrap_d   = 1'b0;
        w_mem_rc = 1'b1;
        w_mem_in = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_valid) begin
                    case (wr_cmd_e'(bus.wr_cmd))
                        CMD_CHAR: begin
                            data_d  = bus.wr_data;
                            state_d = ST_WAIT_COL;
                        end
                        CMD_CR: begin
                            cursor_d = '0;
                            wrap_d   = 1'b1;
                        end
                        CMD_CLEAR: begin
                            // Column 0 arrives on the next cycle when accepted
                            // at the last phase, so skip the wait state.
                            state_d = w_phase_last ? ST_CLEARING : ST_CLEAR_WAIT;
                        end
                        default: ;
                    endcase
                end
            end

            ST_WAIT_COL: begin
                if (w_phase == cursor_q) begin
                    w_mem_rc = 1'b0;
                    w_mem_in = data_q;
                    state_d  = ST_IDLE;
                    if (cursor_q == c_last_col) begin
                        cursor_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                    end
                end
            end

            ST_CLEAR_WAIT: begin
                // Enter CLEARING so that its first cycle is phase 0.
                if (w_phase_last) begin
                    state_d = ST_CLEARING;
                end
            end

            ST_CLEARING: begin
                w_mem_rc = 1'b0;
                w_mem_in = BLANK;
                if (w_phase_last) begin
                    state_d  = ST_IDLE;
                    cursor_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            data_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            data_q   <= data_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.wr_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.mem_rc     = w_mem_rc;
    assign bus.mem_in     = w_mem_in;
    assign bus.cursor_col = cursor_q;
    assign bus.cursor_hit = (w_phase == cursor_q);
    assign bus.line_wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_char_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_write_ctrl
// Description : Self-checking bench for char_write_ctrl. Expected memory
//               writes are queued when commands are issued and matched by a
//               negedge monitor against an independent phase model and row
//               memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_write_ctrl;
    import term_pkg::*;

    localparam int c_depth = 40;

    typedef struct {
        int         col;
        logic [5:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    char_write_ctrl_if #(.WIDTH(6)) bus ();

    char_write_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    exp_t       sb_q[$];
    logic [5:0] mem [c_depth];
    int         ph        = 0;
    int         exp_cursor = 0;
    int         nwr       = 0;
    int         wrap_cnt  = 0;
    bit         mon_en    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Phase model: column at the memory head in the current cycle.
    always @(posedge clk) begin
        if (!rst_n) ph <= 0;
        else        ph <= (ph == c_depth - 1) ? 0 : ph + 1;
    end

    // Monitor: memory model, scoreboard pop, cursor_hit and wrap counting.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cursor_hit", 32'(bus.cursor_hit), 32'(ph == int'(bus.cursor_col)));
            if (bus.mem_rc === 1'b0) begin
                exp_t e;
                mem[ph] = bus.mem_in;
                nwr++;
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_col", 32'(ph), 32'(e.col));
                    chk("wr_data", 32'(bus.mem_in), 32'(e.data));
                end
            end else begin
                chk("idle_mem_in", 32'(bus.mem_in), 32'd0);
            end
            if (bus.line_wrap === 1'b1) wrap_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int k);
        int guard = 0;
        while (ph != k && guard < 100) begin
            tick(1);
            guard++;
        end
        chk("wait_phase_timeout", 32'(ph), 32'(k));
    endtask

    // Drive a command, holding wr_valid until accepted; queue expected writes.
    task automatic send(input logic [1:0] cmd, input logic [5:0] d, output int acc_ph);
        int guard = 0;
        bit got   = 0;
        acc_ph = -1;
        bus.wr_valid = 1'b1;
        bus.wr_cmd   = cmd;
        bus.wr_data  = d;
        while (!got && guard < 200) begin
            got = (bus.wr_ready === 1'b1);
            if (got) begin
                acc_ph = ph;
                case (cmd)
                    2'b00: begin
                        sb_q.push_back('{col: exp_cursor, data: d});
                        exp_cursor = (exp_cursor == c_depth - 1) ? 0 : exp_cursor + 1;
                    end
                    2'b01: exp_cursor = 0;
                    2'b10: begin
                        for (int i = 0; i < c_depth; i++)
                            sb_q.push_back('{col: i, data: 6'h20});
                        exp_cursor = 0;
                    end
                    default: ;
                endcase
            end
            tick(1);
            guard++;
        end
        bus.wr_valid = 1'b0;
        chk("accept_timeout", 32'(got), 32'd1);
    endtask

    // Cycles from the accept edge until the first mem_rc=0 cycle.
    task automatic wait_mem(output int cyc);
        cyc = 1;
        while (bus.mem_rc !== 1'b0 && cyc < 100) begin
            tick(1);
            cyc++;
        end
    endtask

    initial begin
        int acc;
        int cyc;
        int n;
        int snap;
        int bad;

        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_cmd   = 2'b00;
        bus.wr_data  = '0;
        tick(1);
        mon_en = 1;
        tick(1);

        // Reset state
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_rc", 32'(bus.mem_rc), 32'd1);
        chk("rst_mem_in", 32'(bus.mem_in), 32'd0);
        chk("rst_cursor", 32'(bus.cursor_col), 32'd0);
        chk("rst_line_wrap", 32'(bus.line_wrap), 32'd0);
        rst_n = 1'b1;

        // Write 6'h01 at phase 5 with cursor 0: lands at phase 0, 35 cycles on.
        wait_phase(5);
        send(2'b00, 6'h01, acc);
        chk("first_busy", 32'(bus.busy), 32'd1);
        wait_mem(cyc);
        chk("first_latency", 32'(cyc), 32'd35);
        tick(1);
        chk("first_cursor", 32'(bus.cursor_col), 32'd1);
        chk("first_mem0", 32'(mem[0]), 32'h01);

        // CR from cursor 1
        send(2'b01, 6'h00, acc);
        chk("cr1_wrap", 32'(bus.line_wrap), 32'd1);
        chk("cr1_cursor", 32'(bus.cursor_col), 32'd0);
        tick(1);
        chk("cr1_wrap_end", 32'(bus.line_wrap), 32'd0);
        snap = wrap_cnt;

        // 40 back-to-back writes; each next accept on the first IDLE cycle
        for (int i = 0; i < c_depth; i++) begin
            send(2'b00, 6'(i + 8), acc);
            if (i > 0) chk("b2b_accept_ph", 32'(acc), 32'(i));
        end
        wait_mem(cyc);
        chk("row_last_latency", 32'(cyc), 32'd40);
        tick(1);
        chk("row_wrap_pulse", 32'(bus.line_wrap), 32'd1);
        chk("row_cursor", 32'(bus.cursor_col), 32'd0);
        tick(2);
        chk("row_wrap_count", 32'(wrap_cnt - snap), 32'd1);
        bad = 0;
        for (int i = 0; i < c_depth; i++) if (mem[i] !== 6'(i + 8)) bad++;
        chk("row_mem_contents", 32'(bad), 32'd0);
        chk("row_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reserved command is a no-op
        snap = nwr;
        send(2'b11, 6'h3f, acc);
        chk("rsvd_ready", 32'(bus.wr_ready), 32'd1);
        chk("rsvd_cursor", 32'(bus.cursor_col), 32'd0);
        tick(45);
        chk("rsvd_no_write", 32'(nwr - snap), 32'd0);

        // Cursor to 17, then CR
        for (int i = 0; i < 17; i++) send(2'b00, 6'(i + 1), acc);
        wait_mem(cyc);
        tick(1);
        chk("c17_cursor", 32'(bus.cursor_col), 32'd17);
        snap = nwr;
        send(2'b01, 6'h00, acc);
        chk("cr17_wrap", 32'(bus.line_wrap), 32'd1);
        chk("cr17_ready", 32'(bus.wr_ready), 32'd1);
        chk("cr17_cursor", 32'(bus.cursor_col), 32'd0);
        tick(1);
        chk("cr17_wrap_end", 32'(bus.line_wrap), 32'd0);
        tick(40);
        chk("cr17_no_write", 32'(nwr - snap), 32'd0);

        // Clear issued at phase 12: 28 cycles wait, then 40 blank cycles
        wait_phase(12);
        snap = wrap_cnt;
        send(2'b10, 6'h00, acc);
        wait_mem(cyc);
        chk("clr_latency", 32'(cyc), 32'd28);
        n = 0;
        while (bus.mem_rc === 1'b0 && n < 100) begin
            n++;
            tick(1);
        end
        chk("clr_length", 32'(n), 32'd40);
        chk("clr_cursor", 32'(bus.cursor_col), 32'd0);
        chk("clr_ready", 32'(bus.wr_ready), 32'd1);
        tick(2);
        chk("clr_no_wrap", 32'(wrap_cnt - snap), 32'd0);
        bad = 0;
        for (int i = 0; i < c_depth; i++) if (mem[i] !== 6'h20) bad++;
        chk("clr_mem_blank", 32'(bad), 32'd0);
        chk("clr_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of CLEARING at phase 20
        send(2'b00, 6'h05, acc);
        send(2'b00, 6'h06, acc);
        wait_mem(cyc);
        tick(1);
        chk("pre_rst_cursor", 32'(bus.cursor_col), 32'd2);
        send(2'b10, 6'h00, acc);
        n = 0;
        while (!(ph == 20 && bus.mem_rc === 1'b0) && n < 200) begin
            tick(1);
            n++;
        end
        chk("reach_clear_ph20", 32'(ph), 32'd20);
        rst_n = 1'b0;
        tick(1);
        sb_q.delete();
        exp_cursor = 0;
        chk("abort_mem_rc", 32'(bus.mem_rc), 32'd1);
        chk("abort_cursor", 32'(bus.cursor_col), 32'd0);
        chk("abort_ready", 32'(bus.wr_ready), 32'd1);
        chk("abort_phase0_hit", 32'(bus.cursor_hit), 32'd1);
        chk("abort_line_wrap", 32'(bus.line_wrap), 32'd0);
        rst_n = 1'b1;
        snap = nwr;
        tick(60);
        chk("abort_no_write", 32'(nwr - snap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
